// File: rtl/fp_short_norm_round_if.sv
// fp_short_norm_round_if: raw ALU result in, packed short float plus flags out.
interface fp_short_norm_round_if #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 11
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [7:0]             in_exp;
    logic [MAN_W+2:0]       in_mag;
    logic                   in_sticky;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   res_short;
    logic                   ovf;
    logic                   uf;
    logic                   inexact;
    modport master (
        output in_valid, in_sign, in_exp, in_mag, in_sticky, out_ready,
        input  in_ready, out_valid, res_short, ovf, uf, inexact
    );
    modport slave (
        input  in_valid, in_sign, in_exp, in_mag, in_sticky, out_ready,
        output in_ready, out_valid, res_short, ovf, uf, inexact
    );
endinterface

// File: rtl/fp_short_norm_round.sv
// fp_short_norm_round: iterative normalize (one shift per cycle) and round-to-nearest-even to short float.
module fp_short_norm_round #(
    parameter int EXP_W = 4,
    parameter int MAN_W = 11,
    parameter int BIAS  = 7
) (
    input logic                 clk,
    input logic                 reset,
    fp_short_norm_round_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;
    // All-ones biased exponent is reserved for infinity.
    localparam logic signed [8:0] EXP_MAX = 9'(2 * BIAS + 1);
    state_t               state, state_n;
    logic                 sign_r, sticky_r, ovf_r, uf_r, inx_r;
    logic signed [8:0]    exp_r, exp_rnd;
    logic [MAN_W+2:0]     mag_r;
    logic [MAN_W:0]       sum;
    logic [EXP_W+MAN_W:0] res_r;
    logic                 zero, norm, g, rup;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == OUT;
    assign bus.res_short = res_r;
    assign bus.ovf       = ovf_r;
    assign bus.uf        = uf_r;
    assign bus.inexact   = inx_r;
    always_comb begin
        zero    = mag_r == '0;
        norm    = !mag_r[MAN_W+2] && mag_r[MAN_W+1];
        g       = mag_r[0];
        rup     = g & (sticky_r | mag_r[1]);
        sum     = {1'b0, mag_r[MAN_W:1]} + (MAN_W+1)'(rup);
        exp_rnd = exp_r + 9'(sum[MAN_W]);
        state_n = state;
        unique case (state)
            IDLE:  state_n = bus.in_valid ? SHIFT : IDLE;
            SHIFT: state_n = (zero || norm) ? ROUND : SHIFT;
            ROUND: state_n = OUT;
            OUT:   state_n = bus.out_ready ? IDLE : OUT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            sign_r   <= 1'b0;
            sticky_r <= 1'b0;
            exp_r    <= '0;
            mag_r    <= '0;
            res_r    <= '0;
            ovf_r    <= 1'b0;
            uf_r     <= 1'b0;
            inx_r    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    sign_r   <= bus.in_sign;
                    exp_r    <= {bus.in_exp[7], bus.in_exp};
                    mag_r    <= bus.in_mag;
                    sticky_r <= bus.in_sticky;
                end
                SHIFT: if (!zero && mag_r[MAN_W+2]) begin
                    mag_r    <= mag_r >> 1;
                    exp_r    <= exp_r + 9'sd1;
                    sticky_r <= sticky_r | mag_r[0];
                end else if (!zero && !mag_r[MAN_W+1]) begin
                    mag_r <= mag_r << 1;
                    exp_r <= exp_r - 9'sd1;
                end
                ROUND: begin
                    ovf_r <= !zero && exp_rnd >= EXP_MAX;
                    uf_r  <= !zero && exp_rnd < EXP_MAX && exp_rnd <= 9'sd0;
                    inx_r <= !zero && (g || sticky_r || exp_rnd >= EXP_MAX || exp_rnd <= 9'sd0);
                    res_r <= zero ? {sign_r, {(EXP_W+MAN_W){1'b0}}} :
                             exp_rnd >= EXP_MAX ? {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                             exp_rnd <= 9'sd0 ? {sign_r, {(EXP_W+MAN_W){1'b0}}} :
                             {sign_r, exp_rnd[EXP_W-1:0], sum[MAN_W-1:0]};
                end
                OUT: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_short_norm_round.sv
// tb_fp_short_norm_round: directed vector table plus handshake-hold and mid-operation reset sequences.
module tb_fp_short_norm_round;
    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [13:0] mag;
        logic        sticky;
        logic [15:0] res;
        logic        ovf;
        logic        uf;
        logic        inx;
        int          lat;
    } vec_t;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vt[19];
    fp_short_norm_round_if bus ();
    fp_short_norm_round dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic s, input logic [7:0] e, input logic [13:0] m, input logic st);
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mag    = m;
        bus.in_sticky = st;
    endtask
    task automatic start_op(input logic s, input logic [7:0] e, input logic [13:0] m, input logic st,
                            output int n);
        @(negedge clk);
        drive(s, e, m, st);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask
    task automatic run_vec(input int i);
        int n;
        start_op(vt[i].sign, vt[i].exp, vt[i].mag, vt[i].sticky, n);
        chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
        chk($sformatf("v%0d latency", i), 32'(n), 32'(vt[i].lat));
        chk($sformatf("v%0d res_short", i), 32'(bus.res_short), 32'(vt[i].res));
        chk($sformatf("v%0d ovf", i), 32'(bus.ovf), 32'(vt[i].ovf));
        chk($sformatf("v%0d uf", i), 32'(bus.uf), 32'(vt[i].uf));
        chk($sformatf("v%0d inexact", i), 32'(bus.inexact), 32'(vt[i].inx));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("v%0d drained", i), 32'(bus.out_valid), 32'd0);
        chk($sformatf("v%0d idle ready", i), 32'(bus.in_ready), 32'd1);
    endtask
    initial begin
        int n;
        total = 0;
        bad   = 0;
        //         sign exp    mag       st  res       ovf uf inx lat
        vt[0]  = '{1'b0, 8'h07, 14'h1000, 1'b0, 16'h3800, 1'b0, 1'b0, 1'b0, 3};
        vt[1]  = '{1'b0, 8'h07, 14'h2000, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 4};
        vt[2]  = '{1'b0, 8'h0E, 14'h2000, 1'b0, 16'h7800, 1'b1, 1'b0, 1'b1, 4};
        vt[3]  = '{1'b0, 8'h0A, 14'h0200, 1'b0, 16'h3800, 1'b0, 1'b0, 1'b0, 6};
        vt[4]  = '{1'b0, 8'h07, 14'h1FFF, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 3};
        vt[5]  = '{1'b0, 8'h07, 14'h1001, 1'b0, 16'h3800, 1'b0, 1'b0, 1'b1, 3};
        vt[6]  = '{1'b1, 8'h01, 14'h0800, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 4};
        vt[7]  = '{1'b0, 8'h00, 14'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3};
        vt[8]  = '{1'b0, 8'h07, 14'h1003, 1'b0, 16'h3802, 1'b0, 1'b0, 1'b1, 3};
        vt[9]  = '{1'b0, 8'h07, 14'h1000, 1'b1, 16'h3800, 1'b0, 1'b0, 1'b1, 3};
        vt[10] = '{1'b0, 8'hFE, 14'h1000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3};
        vt[11] = '{1'b0, 8'h14, 14'h0001, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0, 15};
        vt[12] = '{1'b0, 8'h0E, 14'h1FFE, 1'b0, 16'h77FF, 1'b0, 1'b0, 1'b0, 3};
        vt[13] = '{1'b0, 8'h07, 14'h2001, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 4};
        vt[14] = '{1'b0, 8'h0E, 14'h1FFF, 1'b0, 16'h7800, 1'b1, 1'b0, 1'b1, 3};
        vt[15] = '{1'b1, 8'h07, 14'h0000, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0, 3};
        vt[16] = '{1'b0, 8'h01, 14'h1000, 1'b0, 16'h0800, 1'b0, 1'b0, 1'b0, 3};
        vt[17] = '{1'b0, 8'h80, 14'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 15};
        vt[18] = '{1'b1, 8'h08, 14'h1555, 1'b0, 16'hC2AA, 1'b0, 1'b0, 1'b1, 3};
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 14'h0000, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset res_short", 32'(bus.res_short), 32'd0);
        chk("reset flags", {29'd0, bus.ovf, bus.uf, bus.inexact}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 19; i++) run_vec(i);
        // Stall the consumer while a new request is offered; result must hold and request be ignored.
        start_op(1'b0, 8'h0E, 14'h2000, 1'b0, n);
        chk("hold reached OUT", 32'(bus.out_valid), 32'd1);
        drive(1'b0, 8'h07, 14'h1000, 1'b0);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("hold%0d res_short", c), 32'(bus.res_short), 32'h7800);
            chk($sformatf("hold%0d flags", c), {29'd0, bus.ovf, bus.uf, bus.inexact}, 32'b101);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release out_valid", 32'(bus.out_valid), 32'd0);
        chk("release res kept", 32'(bus.res_short), 32'h7800);
        chk("release flags kept", {29'd0, bus.ovf, bus.uf, bus.inexact}, 32'b101);
        @(negedge clk);
        chk("release not consumed", 32'(bus.in_ready), 32'd1);
        // Reset in the middle of a long left-normalize.
        @(negedge clk);
        drive(1'b0, 8'h14, 14'h0001, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset busy", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset res_short", 32'(bus.res_short), 32'd0);
        chk("midreset flags", {29'd0, bus.ovf, bus.uf, bus.inexact}, 32'd0);
        reset = 1'b1;
        repeat (14) begin
            @(negedge clk);
            chk("aborted op silent", 32'(bus.out_valid), 32'd0);
        end
        run_vec(4);
        run_vec(11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
